// File: rtl/pll_clk_lockgen.sv
// Behavioural stand-in for the vendor PLL wrapper and its global-reset primitive.
// Measures the clkin1 period in the clk_tb domain and qualifies it against the
// expected frequency. It raises one stable pll_lock once the reference is good,
// and then generates clkout1 from clk_tb while locked.
`timescale 1ns/100ps

module pll_clk_lockgen #(
    parameter int CLKIN_PERIOD_CYC = 10,
    parameter int PERIOD_TOL       = 1,
    parameter int LOCK_CNT         = 8,
    parameter int BAD_MAX          = 3,
    parameter int LOSS_CYC         = 40,
    parameter int OUT_HALF         = 2
) (
    input  logic clk_tb,
    input  logic rst_n,
    input  logic clkin1,
    input  logic pll_rst,
    output logic clkout1,
    output logic pll_lock
);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    localparam logic [16:0] PER_LO    = 17'(CLKIN_PERIOD_CYC - PERIOD_TOL);
    localparam logic [16:0] PER_HI    = 17'(CLKIN_PERIOD_CYC + PERIOD_TOL);
    localparam logic [15:0] LOSS_LIM  = 16'(LOSS_CYC);
    localparam logic [3:0]  LOCK_TGT  = 4'(LOCK_CNT);
    localparam logic [3:0]  BAD_TGT   = 4'(BAD_MAX);
    localparam logic [7:0]  HALF_LAST = 8'(OUT_HALF - 1);

    // Synchronizer and edge-detect state
    logic prst_meta_q, prst_meta_d;
    logic prst_sync_q, prst_sync_d;
    logic ck_meta_q,   ck_meta_d;
    logic ck_sync_q,   ck_sync_d;
    logic ck_prev_q,   ck_prev_d;
    logic edge_q,      edge_d;

    // Measurement and qualification state
    logic [15:0] period_cnt_q, period_cnt_d;
    logic        armed_q,      armed_d;
    logic [3:0]  good_cnt_q,   good_cnt_d;
    logic [3:0]  bad_cnt_q,    bad_cnt_d;
    lock_state_t state_q,      state_d;

    // Output clock generator state
    logic [7:0] half_cnt_q, half_cnt_d;
    logic       clkout_q,   clkout_d;

    // Helper terms for the qualification logic
    logic [16:0] period;
    logic        in_tol;
    logic        loss;
    logic [15:0] cnt_inc;
    logic [3:0]  good_inc;
    logic [3:0]  bad_inc;

    // Two-flop synchronizers for pll_rst and clkin1, plus a registered rising-edge pulse
    always_comb begin
        prst_meta_d = pll_rst;
        prst_sync_d = prst_meta_q;
        ck_meta_d   = clkin1;
        ck_sync_d   = ck_meta_q;
        ck_prev_d   = ck_sync_q;
        edge_d      = ck_sync_q & ~ck_prev_q;
    end

    // Period measurement, lock qualification, and loss-of-reference detection
    always_comb begin
        period   = {1'b0, period_cnt_q} + 17'd1;
        in_tol   = (period >= PER_LO) && (period <= PER_HI);
        loss     = (period_cnt_q >= LOSS_LIM);
        cnt_inc  = (period_cnt_q == 16'hFFFF) ? period_cnt_q : period_cnt_q + 16'd1;
        good_inc = (good_cnt_q == 4'hF) ? good_cnt_q : good_cnt_q + 4'd1;
        bad_inc  = bad_cnt_q + 4'd1;

        period_cnt_d = cnt_inc;
        armed_d      = armed_q;
        good_cnt_d   = good_cnt_q;
        bad_cnt_d    = bad_cnt_q;
        state_d      = state_q;

        if (prst_sync_q) begin
            period_cnt_d = 16'd0;
            armed_d      = 1'b0;
            good_cnt_d   = 4'd0;
            bad_cnt_d    = 4'd0;
            state_d      = ST_UNLOCKED;
        end else if (loss) begin
            state_d    = ST_UNLOCKED;
            good_cnt_d = 4'd0;
            bad_cnt_d  = 4'd0;
            armed_d    = edge_q;
            if (edge_q) begin
                period_cnt_d = 16'd0;
            end
        end else if (edge_q) begin
            period_cnt_d = 16'd0;
            if (!armed_q) begin
                armed_d = 1'b1;
            end else if (state_q == ST_UNLOCKED) begin
                if (in_tol) begin
                    good_cnt_d = good_inc;
                    if (good_inc == LOCK_TGT) begin
                        state_d   = ST_LOCKED;
                        bad_cnt_d = 4'd0;
                    end
                end else begin
                    good_cnt_d = 4'd0;
                end
            end else begin
                if (in_tol) begin
                    bad_cnt_d = 4'd0;
                end else if (bad_inc == BAD_TGT) begin
                    state_d    = ST_UNLOCKED;
                    good_cnt_d = 4'd0;
                    bad_cnt_d  = 4'd0;
                    armed_d    = 1'b0;
                end else begin
                    bad_cnt_d = bad_inc;
                end
            end
        end
    end

    // clkout1 runs only while lock is held; it is forced low in the cycle lock falls
    always_comb begin
        half_cnt_d = 8'd0;
        clkout_d   = 1'b0;
        if ((state_q == ST_LOCKED) && (state_d == ST_LOCKED)) begin
            if (half_cnt_q == HALF_LAST) begin
                half_cnt_d = 8'd0;
                clkout_d   = ~clkout_q;
            end else begin
                half_cnt_d = half_cnt_q + 8'd1;
                clkout_d   = clkout_q;
            end
        end
    end

    // State registers with asynchronous active-low global reset
    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            prst_meta_q  <= 1'b0;
            prst_sync_q  <= 1'b0;
            ck_meta_q    <= 1'b0;
            ck_sync_q    <= 1'b0;
            ck_prev_q    <= 1'b0;
            edge_q       <= 1'b0;
            period_cnt_q <= 16'd0;
            armed_q      <= 1'b0;
            good_cnt_q   <= 4'd0;
            bad_cnt_q    <= 4'd0;
            state_q      <= ST_UNLOCKED;
            half_cnt_q   <= 8'd0;
            clkout_q     <= 1'b0;
        end else begin
            prst_meta_q  <= prst_meta_d;
            prst_sync_q  <= prst_sync_d;
            ck_meta_q    <= ck_meta_d;
            ck_sync_q    <= ck_sync_d;
            ck_prev_q    <= ck_prev_d;
            edge_q       <= edge_d;
            period_cnt_q <= period_cnt_d;
            armed_q      <= armed_d;
            good_cnt_q   <= good_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
            state_q      <= state_d;
            half_cnt_q   <= half_cnt_d;
            clkout_q     <= clkout_d;
        end
    end

    assign pll_lock = (state_q == ST_LOCKED);
    assign clkout1  = clkout_q;

endmodule

// File: tb/tb_pll_clk_lockgen.sv
// Directed self-checking bench for pll_clk_lockgen: acquisition, relock after
// pll_rst, off-frequency reference, glitch tolerance, reference loss, and async reset.
`timescale 1ns/100ps

module tb_pll_clk_lockgen;

    logic clk_tb;
    logic rst_n;
    logic clkin1;
    logic pll_rst;
    logic clkout1;
    logic pll_lock;

    int checks   = 0;
    int failures = 0;

    // Reference clock generator controls
    bit clkin_en   = 1'b1;
    int clkin_half = 10;
    int short_req  = 0;
    int short_done = 0;
    int gen_half   = 10;

    // Event monitors
    int clkin_rises     = 0;
    int lock_rises      = 0;
    int lock_falls      = 0;
    int clkout_high_cnt = 0;
    logic lock_prev     = 1'b0;

    pll_clk_lockgen dut (
        .clk_tb   (clk_tb),
        .rst_n    (rst_n),
        .clkin1   (clkin1),
        .pll_rst  (pll_rst),
        .clkout1  (clkout1),
        .pll_lock (pll_lock)
    );

    // 2 ns measurement clock, rising edges at odd ns
    initial begin
        clk_tb = 1'b0;
        forever #1 clk_tb = ~clk_tb;
    end

    // Reference clock with 0.3 ns phase offset; short_req requests 14 ns periods
    initial begin
        clkin1 = 1'b0;
        #0.3;
        forever begin
            if (!clkin_en) begin
                clkin1 = 1'b0;
                #1;
            end else begin
                if (short_done < short_req) begin
                    gen_half   = 7;
                    short_done = short_done + 1;
                end else begin
                    gen_half = clkin_half;
                end
                clkin1 = 1'b1;
                #(gen_half);
                clkin1 = 1'b0;
                #(gen_half);
            end
        end
    end

    always @(posedge clkin1) clkin_rises = clkin_rises + 1;

    always @(negedge clk_tb) begin
        if (pll_lock === 1'b1 && lock_prev === 1'b0) lock_rises = lock_rises + 1;
        if (pll_lock === 1'b0 && lock_prev === 1'b1) lock_falls = lock_falls + 1;
        if (clkout1 === 1'b1) clkout_high_cnt = clkout_high_cnt + 1;
        lock_prev = pll_lock;
    end

    task automatic wait_lock(input logic level, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk_tb);
            if (pll_lock === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        pll_rst = 1'b0;
        repeat (5) @(negedge clk_tb);
        checks++;
        if (pll_lock !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_lock: got %b expected 0", pll_lock);
        end
        checks++;
        if (clkout1 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_clkout: got %b expected 0", clkout1);
        end
    endtask

    task automatic test_nominal;
        bit ok;
        int snap;
        int edges;
        logic [7:0] pattern;
        int falls_snap;
        @(negedge clk_tb);
        rst_n = 1'b1;
        #20;
        pll_rst = 1'b1;
        @(posedge clkin1);
        #10;
        pll_rst = 1'b0;
        snap = clkin_rises;
        wait_lock(1'b1, 300, ok);
        edges = clkin_rises - snap;
        pattern = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk_tb);
            pattern = {pattern[6:0], clkout1};
        end
        checks++;
        if (!ok || edges != 9) begin
            failures++;
            $display("[TB] FAIL nominal_lock_edges: locked=%0d edges=%0d expected locked=1 edges=9", ok, edges);
        end
        checks++;
        if (pattern !== 8'b0011_0011) begin
            failures++;
            $display("[TB] FAIL nominal_clkout_pattern: got %b expected 00110011", pattern);
        end
        falls_snap = lock_falls;
        repeat (5000) @(negedge clk_tb);
        checks++;
        if (lock_rises != 1) begin
            failures++;
            $display("[TB] FAIL nominal_single_rise: got %0d rises expected 1", lock_rises);
        end
        checks++;
        if (pll_lock !== 1'b1 || lock_falls != falls_snap) begin
            failures++;
            $display("[TB] FAIL nominal_stable: lock=%b falls=%0d expected lock=1 falls=%0d", pll_lock, lock_falls, falls_snap);
        end
    endtask

    task automatic test_pll_rst_locked;
        bit ok;
        int snap;
        int edges;
        @(posedge clkin1);
        #10;
        pll_rst = 1'b1;
        repeat (2) @(posedge clk_tb);
        @(negedge clk_tb);
        checks++;
        if (pll_lock !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pllrst_sync_delay: lock=%b after 2 cycles expected 1", pll_lock);
        end
        @(posedge clk_tb);
        @(negedge clk_tb);
        checks++;
        if (pll_lock !== 1'b0 || clkout1 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL pllrst_drop: lock=%b clkout=%b expected 0 0", pll_lock, clkout1);
        end
        repeat (10) @(negedge clk_tb);
        @(posedge clkin1);
        #10;
        pll_rst = 1'b0;
        snap = clkin_rises;
        wait_lock(1'b1, 300, ok);
        edges = clkin_rises - snap;
        checks++;
        if (!ok || edges != 9) begin
            failures++;
            $display("[TB] FAIL pllrst_relock_edges: locked=%0d edges=%0d expected locked=1 edges=9", ok, edges);
        end
    endtask

    task automatic test_glitch;
        bit ok;
        int snap;
        int edges;
        int falls_snap;
        falls_snap = lock_falls;
        @(posedge clkin1);
        #1;
        short_req = short_req + 1;
        repeat (80) @(negedge clk_tb);
        checks++;
        if (pll_lock !== 1'b1 || lock_falls != falls_snap) begin
            failures++;
            $display("[TB] FAIL glitch_single: lock=%b falls=%0d expected lock=1 falls=%0d", pll_lock, lock_falls, falls_snap);
        end
        @(posedge clkin1);
        #1;
        short_req = short_req + 2;
        repeat (80) @(negedge clk_tb);
        checks++;
        if (pll_lock !== 1'b1 || lock_falls != falls_snap) begin
            failures++;
            $display("[TB] FAIL glitch_two_bad: lock=%b falls=%0d expected lock=1 falls=%0d", pll_lock, lock_falls, falls_snap);
        end
        @(posedge clkin1);
        #1;
        short_req = short_req + 3;
        wait_lock(1'b0, 100, ok);
        snap = clkin_rises;
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL glitch_three_bad: lock=%b expected 0", pll_lock);
        end
        wait_lock(1'b1, 300, ok);
        edges = clkin_rises - snap;
        checks++;
        if (!ok || edges != 9) begin
            failures++;
            $display("[TB] FAIL glitch_relock_edges: locked=%0d edges=%0d expected locked=1 edges=9", ok, edges);
        end
    endtask

    task automatic test_loss;
        bit ok;
        bit seen;
        int snap;
        int edges;
        realtime t_last;
        realtime t_fall;
        realtime delta;
        @(posedge clkin1);
        t_last = $realtime;
        #1;
        clkin_en = 1'b0;
        seen   = 1'b0;
        t_fall = 0.0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_tb);
            if (pll_lock === 1'b0) begin
                t_fall = $realtime - 1.0;
                seen   = 1'b1;
                break;
            end
        end
        delta = t_fall - t_last;
        checks++;
        if (!seen || delta < 88.0 || delta > 90.0) begin
            failures++;
            $display("[TB] FAIL loss_timing: seen=%0d delay=%0.1f ns expected 88.0..90.0 ns", seen, delta);
        end
        repeat (20) @(negedge clk_tb);
        snap = clkin_rises;
        clkin_en = 1'b1;
        wait_lock(1'b1, 400, ok);
        edges = clkin_rises - snap;
        checks++;
        if (!ok || edges != 9) begin
            failures++;
            $display("[TB] FAIL loss_relock_edges: locked=%0d edges=%0d expected locked=1 edges=9", ok, edges);
        end
    endtask

    task automatic test_off_freq;
        bit ok;
        int rises_snap;
        int high_snap;
        pll_rst    = 1'b1;
        clkin_half = 14;
        repeat (10) @(negedge clk_tb);
        pll_rst    = 1'b0;
        rises_snap = lock_rises;
        high_snap  = clkout_high_cnt;
        repeat (1500) @(negedge clk_tb);
        checks++;
        if (pll_lock !== 1'b0 || lock_rises != rises_snap) begin
            failures++;
            $display("[TB] FAIL offfreq_no_lock: lock=%b rises=%0d expected lock=0 rises=%0d", pll_lock, lock_rises, rises_snap);
        end
        checks++;
        if (clkout_high_cnt != high_snap) begin
            failures++;
            $display("[TB] FAIL offfreq_clkout_low: high samples=%0d expected %0d", clkout_high_cnt, high_snap);
        end
        clkin_half = 10;
        wait_lock(1'b1, 400, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL offfreq_recover: lock=%b expected 1", pll_lock);
        end
    endtask

    task automatic test_async_reset;
        bit ok;
        int snap;
        int edges;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_tb);
            if (clkout1 === 1'b1) break;
        end
        #0.5;
        rst_n = 1'b0;
        #0.2;
        checks++;
        if (pll_lock !== 1'b0 || clkout1 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset_outputs: lock=%b clkout=%b expected 0 0", pll_lock, clkout1);
        end
        #20;
        @(posedge clkin1);
        #10;
        rst_n = 1'b1;
        snap = clkin_rises;
        wait_lock(1'b1, 300, ok);
        edges = clkin_rises - snap;
        checks++;
        if (!ok || edges != 9) begin
            failures++;
            $display("[TB] FAIL async_reset_relock_edges: locked=%0d edges=%0d expected locked=1 edges=9", ok, edges);
        end
        repeat (4) @(negedge clk_tb);
        checks++;
        if (lock_rises != 6) begin
            failures++;
            $display("[TB] FAIL total_lock_rises: got %0d expected 6", lock_rises);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        pll_rst = 1'b0;
        $display("[TB] start");
        test_reset();
        test_nominal();
        test_pll_rst_locked();
        test_glitch();
        test_loss();
        test_off_freq();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
